lut_neuron_rw: RTL and testbench

- Parametrised, runtime-loadable LUT neuron for the fidelity-optimised LogicNets datapath.
- Truth table lives in distributed RAM of 2^IN_BITS x OUT_BITS instead of being hard-coded.
- Table is loaded serially through a config port; lookups then run behind a registered valid/ready stream, one per cycle.
- Lets one netlist serve retrained layers without resynthesis.

---
 rtl/lut_neuron_rw.sv | 157 +++++++++++++++
 tb/tb_lut_neuron_rw.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_rw.sv
// Runtime-loadable LUT neuron: the truth table is loaded serially into distributed RAM, then served one lookup per cycle.
// Optional load checksum (cfg_chk / cfg_err ports) is compiled in with LUT_NEURON_CHECKSUM_EN.
module lut_neuron_rw #(
  parameter int IN_BITS  = 7,
  parameter int OUT_BITS = 2,
  parameter int DEPTH    = 2**IN_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [OUT_BITS-1:0] cfg_data,
`ifdef LUT_NEURON_CHECKSUM_EN
  input  logic [15:0]         cfg_chk,
  output logic                cfg_err,
`endif
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                tbl_loaded,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data,
  input  logic                out_ready,
  output logic [1:0]          dbg_state
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  // Ready is combinational from state, out_valid, out_ready and cfg_start; valid never
  // depends on ready. in_ready is held low during a cfg_start cycle so no lookup slips in.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int ADDR_W = IN_BITS + 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic                start_pend;
  logic                load_enter;
  logic                wr_en;
  logic                last_beat;
  logic                chk_ok;
  logic                accept;
  logic [OUT_BITS-1:0] mem [DEPTH];

  assign wr_en     = (state == LOAD) && cfg_valid && !cfg_start;
  assign last_beat = wr_en && (addr == ADDR_W'(DEPTH - 1));
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_enter = 1'b0;
    case (state)
      EMPTY: begin
        if (cfg_start) begin
          state_nxt  = LOAD;
          load_enter = 1'b1;
        end
      end
      LOAD: begin
        if (cfg_start)      load_enter = 1'b1;
        else if (last_beat) state_nxt  = chk_ok ? RUN : EMPTY;
      end
      RUN: begin
        if (cfg_start) begin
          if (out_valid) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt  = LOAD;
            load_enter = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Leave once the held result has been taken (or already is gone).
        if (start_pend && (!out_valid || out_ready)) begin
          state_nxt  = LOAD;
          load_enter = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    cfg_ready = (state == LOAD);
    in_ready  = (state == RUN) && !cfg_start && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      start_pend <= 1'b0;
      cfg_done   <= 1'b0;
      tbl_loaded <= 1'b0;
    end else begin
      cfg_done   <= last_beat && chk_ok;
      tbl_loaded <= (state_nxt == RUN);
      if (load_enter)                              start_pend <= 1'b0;
      else if (state == RUN && cfg_start && out_valid) start_pend <= 1'b1;
      if (load_enter)  addr <= '0;
      else if (wr_en)  addr <= addr + ADDR_W'(1);
    end
  end

  // Table storage: written only during LOAD, read asynchronously, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr[IN_BITS-1:0]] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mem[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LUT_NEURON_CHECKSUM_EN
  logic [15:0] sum;
  logic [15:0] chk_reg;

  assign chk_ok = ((sum + 16'(cfg_data)) == chk_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      chk_reg <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= last_beat && !chk_ok;
      if (cfg_start && state != DRAIN) chk_reg <= cfg_chk;
      if (load_enter)  sum <= '0;
      else if (wr_en)  sum <= sum + 16'(cfg_data);
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

endmodule

// File: tb/tb_lut_neuron_rw.sv
// Self-checking bench for lut_neuron_rw: serial table loads, lookup streams and reload paths against a table model.
module tb_lut_neuron_rw;
  localparam int IN_BITS  = 7;
  localparam int OUT_BITS = 2;
  localparam int DEPTH    = 128;
  localparam logic [1:0] S_EMPTY = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic                cfg_valid = 1'b0;
  logic [OUT_BITS-1:0] cfg_data = '0;
  logic [15:0]         cfg_chk = '0;
  logic                cfg_err;
  logic                cfg_ready, cfg_done, tbl_loaded;
  logic                in_valid = 1'b0;
  logic [IN_BITS-1:0]  in_data = '0;
  logic                in_ready, out_valid;
  logic [OUT_BITS-1:0] out_data;
  logic                out_ready = 1'b0;
  logic [1:0]          dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [OUT_BITS-1:0] model_tbl [DEPTH];
  logic [OUT_BITS-1:0] load_src  [DEPTH];
  logic [OUT_BITS-1:0] exp_q [$];

  lut_neuron_rw dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
`ifdef LUT_NEURON_CHECKSUM_EN
    .cfg_chk    (cfg_chk),
    .cfg_err    (cfg_err),
`endif
    .cfg_ready  (cfg_ready),
    .cfg_done   (cfg_done),
    .tbl_loaded (tbl_loaded),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .dbg_state  (dbg_state)
  );

`ifndef LUT_NEURON_CHECKSUM_EN
  assign cfg_err = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- model helpers ----------------
  function automatic logic [15:0] src_sum();
    logic [15:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + 16'(load_src[i]);
    return s;
  endfunction

  task automatic commit_table();
    for (int i = 0; i < DEPTH; i++) model_tbl[i] = load_src[i];
  endtask

  // ---------------- driver: serial table load ----------------
  task automatic drive_load(input int n_beats, input logic gapped, input logic [15:0] chk,
                            output int done_n, output int done_lat, output int err_n,
                            output logic timed_out);
    int k = 0;
    int c = 0;
    int last_acc = -1;
    done_n = 0; err_n = 0; done_lat = -1;
    in_valid  = 1'b0;
    cfg_start = 1'b1;
    cfg_chk   = chk;
    cfg_valid = 1'b1;
    cfg_data  = ~load_src[0];
    @(negedge clk);
    next_cycle();
    cfg_start = 1'b0;
    while (k < n_beats && c < 1000) begin
      cfg_valid = gapped ? (c % 3 != 2) : 1'b1;
      cfg_data  = load_src[k];
      @(negedge clk);
      if (cfg_done) begin done_n++; done_lat = c - last_acc; end
      if (cfg_err) err_n++;
      if (cfg_valid && cfg_ready) begin k++; last_acc = c; end
      next_cycle();
      c++;
    end
    cfg_valid = 1'b0;
    timed_out = (k < n_beats);
    repeat (3) begin
      @(negedge clk);
      if (cfg_done) begin done_n++; done_lat = c - last_acc; end
      if (cfg_err) err_n++;
      next_cycle();
      c++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_EMPTY) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_EMPTY); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_cfg_ready: got %b want 0", cfg_ready); end
    n_cmp++; if (cfg_done !== 1'b0) begin n_err++; $display("FAIL reset_cfg_done: got %b want 0", cfg_done); end
    n_cmp++; if (tbl_loaded !== 1'b0) begin n_err++; $display("FAIL reset_tbl_loaded: got %b want 0", tbl_loaded); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    apply_reset();
  endtask

  task automatic test_no_table();
    in_valid = 1'b1; in_data = 7'd5; out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL empty_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (tbl_loaded !== 1'b0) begin n_err++; $display("FAIL empty_tbl_loaded: got %b want 0", tbl_loaded); end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_load();
    int dn, dl, en;
    logic to;
    for (int i = 0; i < DEPTH; i++) load_src[i] = OUT_BITS'(i % 4);
    drive_load(DEPTH, 1'b1, src_sum(), dn, dl, en, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL load_timeout: got %b want 0", to); end
    n_cmp++; if (dn != 1) begin n_err++; $display("FAIL load_done_count: got %0d want 1", dn); end
    n_cmp++; if (dl != 1) begin n_err++; $display("FAIL load_done_latency: got %0d want 1", dl); end
    @(negedge clk);
    n_cmp++; if (tbl_loaded !== 1'b1) begin n_err++; $display("FAIL load_tbl_loaded: got %b want 1", tbl_loaded); end
    n_cmp++; if (dbg_state !== S_RUN) begin n_err++; $display("FAIL load_state: got %0d want %0d", dbg_state, S_RUN); end
    next_cycle();
    commit_table();
  endtask

  // ph 0: sequential addresses, out_ready=1; ph 1: sequential, out_ready 1010; ph 2: random.
  task automatic test_lookup(input int ph, input int n);
    int issued = 0;
    int got = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [OUT_BITS-1:0] held_data = '0;
    logic [OUT_BITS-1:0] e;
    logic acc;
    exp_q.delete();
    in_valid = 1'b0;
    acc = 1'b0;
    while ((issued < n || got < n) && cyc < 3000) begin
      if (issued < n) begin
        if (!in_valid || acc) begin
          in_valid = (ph == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
          in_data  = (ph == 2) ? IN_BITS'($urandom_range(0, DEPTH - 1)) : IN_BITS'(issued);
        end
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (ph == 0) ? 1'b1 : (ph == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++; if (in_ready !== (!out_valid || out_ready)) begin n_err++; $display("FAIL lookup_in_ready ph%0d: got %b want %b", ph, in_ready, (!out_valid || out_ready)); end
      if (held) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== held_data) begin n_err++; $display("FAIL lookup_hold ph%0d: got v=%b d=%0h want v=1 d=%0h", ph, out_valid, out_data, held_data); end
      end
      if (ph == 0 && cyc >= 1 && cyc <= n) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lookup_bubble cyc%0d: got %b want 1", cyc, out_valid); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL lookup_spurious ph%0d: got %0h want none", ph, out_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL lookup_data ph%0d: got %0h want %0h", ph, out_data, e); end
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin exp_q.push_back(model_tbl[in_data]); issued++; end
      held = out_valid && !out_ready;
      held_data = out_data;
      next_cycle();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != n) begin n_err++; $display("FAIL lookup_count ph%0d: got %0d want %0d", ph, got, n); end
    next_cycle();
  endtask

  task automatic test_drain_reload();
    int dn, dl, en;
    logic to;
    in_valid = 1'b1; in_data = 7'd10; out_ready = 1'b0; cfg_start = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_pre_in_ready: got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0; cfg_start = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL drain_start_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (tbl_loaded !== 1'b1) begin n_err++; $display("FAIL drain_start_tbl_loaded: got %b want 1", tbl_loaded); end
    next_cycle();
    cfg_start = 1'b0; in_valid = 1'b1; in_data = 7'd3;
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_DRAIN) begin n_err++; $display("FAIL drain_state: got %0d want %0d", dbg_state, S_DRAIN); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL drain_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL drain_cfg_ready: got %b want 0", cfg_ready); end
    n_cmp++; if (tbl_loaded !== 1'b0) begin n_err++; $display("FAIL drain_tbl_loaded: got %b want 0", tbl_loaded); end
    next_cycle();
    in_valid = 1'b0; cfg_start = 1'b1;
    next_cycle();
    cfg_start = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_DRAIN) begin n_err++; $display("FAIL drain_absorb_state: got %0d want %0d", dbg_state, S_DRAIN); end
    n_cmp++; if (out_data !== model_tbl[10]) begin n_err++; $display("FAIL drain_hold_data: got %0h want %0h", out_data, model_tbl[10]); end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== model_tbl[10]) begin n_err++; $display("FAIL drain_release: got v=%b d=%0h want v=1 d=%0h", out_valid, out_data, model_tbl[10]); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_LOAD) begin n_err++; $display("FAIL drain_to_load: got %0d want %0d", dbg_state, S_LOAD); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL drain_load_cfg_ready: got %b want 1", cfg_ready); end
    next_cycle();
    for (int i = 0; i < DEPTH; i++) load_src[i] = 2'b11;
    drive_load(DEPTH, 1'b0, src_sum(), dn, dl, en, to);
    n_cmp++; if (to !== 1'b0 || dn != 1 || dl != 1) begin n_err++; $display("FAIL reload_done: got to=%b n=%0d lat=%0d want to=0 n=1 lat=1", to, dn, dl); end
    commit_table();
    in_valid = 1'b1; in_data = 7'd42; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reload_in_ready: got %b want 1", in_ready); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== model_tbl[42]) begin n_err++; $display("FAIL reload_lookup42: got v=%b d=%0h want v=1 d=%0h", out_valid, out_data, model_tbl[42]); end
    next_cycle();
  endtask

  task automatic test_restart_reset();
    int dn1, dn2, dn3, dl, en;
    logic to;
    for (int i = 0; i < DEPTH; i++) load_src[i] = OUT_BITS'($urandom_range(0, 3));
    drive_load(60, 1'b0, 16'd0, dn1, dl, en, to);
    for (int i = 0; i < DEPTH; i++) load_src[i] = OUT_BITS'($urandom_range(0, 3));
    drive_load(30, 1'b1, 16'd0, dn2, dl, en, to);
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_LOAD) begin n_err++; $display("FAIL restart_state: got %0d want %0d", dbg_state, S_LOAD); end
    n_cmp++; if (dn1 + dn2 != 0) begin n_err++; $display("FAIL restart_done: got %0d want 0", dn1 + dn2); end
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_EMPTY) begin n_err++; $display("FAIL midload_reset_state: got %0d want %0d", dbg_state, S_EMPTY); end
    n_cmp++; if (tbl_loaded !== 1'b0 || cfg_done !== 1'b0) begin n_err++; $display("FAIL midload_reset_flags: got tl=%b done=%b want 0 0", tbl_loaded, cfg_done); end
    next_cycle();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 7'd7;
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0 || tbl_loaded !== 1'b0) begin n_err++; $display("FAIL postreset_idle: got rdy=%b tl=%b want 0 0", in_ready, tbl_loaded); end
      next_cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) load_src[i] = OUT_BITS'($urandom_range(0, 3));
    drive_load(DEPTH, 1'b1, src_sum(), dn3, dl, en, to);
    n_cmp++; if (to !== 1'b0 || dn3 != 1 || dl != 1) begin n_err++; $display("FAIL fresh_load_done: got to=%b n=%0d lat=%0d want to=0 n=1 lat=1", to, dn3, dl); end
    commit_table();
  endtask

`ifdef LUT_NEURON_CHECKSUM_EN
  task automatic test_checksum();
    int dn, dl, en;
    logic to;
    for (int i = 0; i < DEPTH; i++) load_src[i] = 2'b01;
    drive_load(DEPTH, 1'b0, 16'd128, dn, dl, en, to);
    n_cmp++; if (dn != 1 || en != 0) begin n_err++; $display("FAIL chk_good: got done=%0d err=%0d want 1 0", dn, en); end
    commit_table();
    drive_load(DEPTH, 1'b0, 16'd127, dn, dl, en, to);
    n_cmp++; if (dn != 0 || en != 1) begin n_err++; $display("FAIL chk_bad: got done=%0d err=%0d want 0 1", dn, en); end
    in_valid = 1'b1; in_data = 7'd1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== S_EMPTY) begin n_err++; $display("FAIL chk_bad_state: got %0d want %0d", dbg_state, S_EMPTY); end
    n_cmp++; if (in_ready !== 1'b0 || tbl_loaded !== 1'b0) begin n_err++; $display("FAIL chk_bad_flags: got rdy=%b tl=%b want 0 0", in_ready, tbl_loaded); end
    next_cycle();
    in_valid = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_no_table();
    test_load();
    test_lookup(0, DEPTH);
    test_lookup(1, DEPTH);
    test_lookup(2, 200);
    test_drain_reload();
    test_restart_reset();
    test_lookup(2, 200);
`ifdef LUT_NEURON_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
